load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  CPU-side initiator for the single-cycle-read data memory (MemRead/MemWrite/addr/data_in/data_out).
//  Accepts one load/store request at a time and runs a small FSM that issues word accesses.
//  Loads: lane extraction with sign/zero extension. Stores: word write direct; byte/half via read-modify-write.
//  Sits between the execute stage and the data memory; CPU stalls while req_ready=0.
// PARAMETERS
//  ADDR_W  8  byte-address width; mem_addr = req_addr[ADDR_W-1:2] (64 words at default)
// PORTS
//  clk         in   1         clock, all state updates on posedge
//  rst         in   1         synchronous, active-high reset
//  req_valid   in   1         request present; accepted when req_valid && req_ready
//  req_ready   out  1         high only in IDLE
//  req_store   in   1         1=store, 0=load
//  req_funct3  in   3         RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores)
//  req_addr    in   ADDR_W    byte address
//  req_wdata   in   32        store data; low byte/half used for sb/sh
//  resp_valid  out  1         one-cycle pulse: request complete
//  resp_rdata  out  32        load result, valid with resp_valid; 0 for stores and errors
//  resp_err    out  1         error flag with resp_valid (feature-dependent, see CONFIGURATION)
//  mem_read    out  1         to memory MemRead
//  mem_write   out  1         to memory MemWrite
//  mem_addr    out  ADDR_W-2  to memory word address
//  mem_wdata   out  32        to memory data_in
//  mem_rdata   in   32        from memory data_out (combinational, same cycle as mem_read)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0,
//   mem_addr=0, mem_wdata=0. Request fields are latched on acceptance; inputs are ignored afterwards.
//  States: IDLE, READ, WRITE, RESP. mem_read=1 only in READ; mem_write=1 only in WRITE.
//  mem_addr/mem_wdata are held from latched regs.
//   IDLE  -accept load (legal)->READ; accept sw->WRITE; accept sb/sh->READ; illegal/error->RESP.
//   READ  -capture mem_rdata at posedge; load->RESP; sb/sh->WRITE with merged word.
//   WRITE -memory commits at the end of this cycle; ->RESP.
//   RESP  -resp_valid=1 for exactly one cycle; ->IDLE (req_ready=1 next cycle).
//  Latency from the accept edge to the resp_valid cycle: load 2, sw 2, sb/sh 3, illegal 1.
//  No back-to-back accept: there is always >=1 IDLE cycle between accepts.
//  Lanes are little-endian. Byte lane = addr[1:0]; half lane = addr[1].
//   lb/lh sign-extend; lbu/lhu zero-extend.
//   Merge replaces only the target lane of the read word.
//  Illegal funct3 (load 011/110/111, store 1xx/011): no memory access; resp_rdata=0.
//  Misaligned: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
//  rst during any state: IDLE at that edge, no resp_valid; the mem_write of a WRITE cycle still
//   commits at that same edge (memory samples mem_write simultaneously).
//   A READ interrupted by rst never writes.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: misaligned or illegal request -> no memory access, RESP with
//   resp_err=1, resp_rdata=0.
//  Undefined: resp_err is constant 0. Misaligned addresses are force-aligned (addr[0] cleared for
//   half, addr[1:0] cleared for word) and executed normally. Illegal funct3 still does no access
//   and returns rdata 0.
// TESTING
//  1 mem[1]=0x12345678; lw 0x04 -> mem_read=1 one cycle with mem_addr=1; resp_rdata=0x12345678
//    2 cycles after accept; resp_err=0.
//  2 mem[1]=0x80345678: lb 0x07 -> 0xFFFFFF80; lbu 0x07 -> 0x00000080; lhu 0x06 -> 0x00008034;
//    lh 0x06 -> 0xFFFF8034.
//  3 mem[1]=0x12345678; sb 0x05 wdata 0x000000AB -> READ, WRITE(mem_wdata=0x1234AB78), RESP at
//    +3; later lw 0x04 returns 0x1234AB78.
//  4 sw 0x08 wdata 0xDEADBEEF -> mem_read never high; one mem_write cycle with mem_addr=2;
//    lw 0x08 returns 0xDEADBEEF.
//  5 lw 0x06 -> with LSU_MISALIGN_TRAP_EN: resp_err=1, rdata 0, no mem_read; without: reads mem[1].
//    funct3=011 load -> rdata 0, no access.
//  6 sh 0x04 accepted, rst high in READ -> next cycle IDLE, req_ready=1; no mem_write, no
//    resp_valid; mem[1] unchanged.

Source files
------------

// File: rtl/lsu_if.sv
// Execute-stage request/response and data-memory port bundle for the load/store unit.
// slave = LSU side, master = CPU + memory side.
interface lsu_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word accesses to a single-cycle-read memory,
// sub-word stores by read-modify-write. LSU_MISALIGN_TRAP_EN: misaligned/illegal -> resp_err.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_store;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;

    logic              w_legal;
    logic              w_half;
    logic              w_word;
    logic              w_misal;
    logic              w_fail;
    logic [1:0]        w_lane;
    logic [31:0]       w_shift;
    logic [31:0]       w_ext;
    logic [3:0]        w_bmask;
    logic [31:0]       w_rep;
    logic [31:0]       w_merged;

    // Request decode, evaluated on the accept cycle only
    always_comb begin
        w_legal = 1'b0;
        if (bus.req_store)
            w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                      (bus.req_funct3 == 3'b010);
        else
            w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                      (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                      (bus.req_funct3 == 3'b101);
    end

    assign w_half  = (bus.req_funct3[1:0] == 2'b01);
    assign w_word  = (bus.req_funct3[1:0] == 2'b10);
    assign w_misal = (w_half && bus.req_addr[0]) || (w_word && (bus.req_addr[1:0] != 2'b00));
    // Lane offset with misaligned bits dropped (force-align)
    assign w_lane  = w_word ? 2'b00 : (w_half ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_fail       = !w_legal || w_misal;
    assign bus.resp_err = r_err;
`else
    assign w_fail       = !w_legal;
    assign bus.resp_err = 1'b0;
`endif

    // Load lane extraction
    assign w_shift = bus.mem_rdata >> {r_lane, 3'b000};
    always_comb begin
        w_ext = w_shift;
        case (r_f3)
            3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ext = {24'd0, w_shift[7:0]};
            3'b101:  w_ext = {16'd0, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Sub-word store merge: only the target lane of the read word is replaced
    assign w_bmask = r_f3[0] ? (4'b0011 << {r_lane[1], 1'b0}) : (4'b0001 << r_lane);
    assign w_rep   = r_f3[0] ? {2{r_wdata}} : {4{r_wdata[7:0]}};
    always_comb begin
        w_merged = bus.mem_rdata;
        for (int i = 0; i < 4; i++)
            if (w_bmask[i]) w_merged[i*8 +: 8] = w_rep[i*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_f3        <= 3'd0;
            r_lane      <= 2'd0;
            r_wdata     <= 16'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_store    <= bus.req_store;
                        r_f3       <= bus.req_funct3;
                        r_lane     <= w_lane;
                        r_wdata    <= bus.req_wdata[15:0];
                        r_mem_addr <= bus.req_addr[ADDR_W-1:2];
                        r_rdata    <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_err      <= w_fail;
`endif
                        if (w_fail) begin
                            r_state <= S_RESP;
                        end else if (bus.req_store && w_word) begin
                            r_mem_wdata <= bus.req_wdata;
                            r_state     <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_store) begin
                        r_mem_wdata <= w_merged;
                        r_state     <= S_WRITE;
                    end else begin
                        r_rdata <= w_ext;
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_read   = (r_state == S_READ);
    assign bus.mem_write  = (r_state == S_WRITE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: request table with a response scoreboard, plus reset-abort sequences.
module tb_load_store_unit;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          nrd;
        int          nwr;
        logic [5:0]  ma;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   nrd = 0, nwr = 0;
    logic [5:0]  last_ma = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] mem [64];
    exp_t q[$];
    vec_t tbl[28];

    lsu_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, write committed at the edge regardless of rst
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [7:0] addr,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee,
                                input int lat, input int nr, input int nw, input logic [5:0] ma,
                                input logic [31:0] ewd);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.er = er; v.ee = ee;
        v.lat = lat; v.nrd = nr; v.nwr = nw; v.ma = ma; v.ewd = ewd;
        return v;
    endfunction

    // Scoreboard monitor: counts memory activity of the outstanding request, checks on resp_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                if (bus.mem_read)  begin nrd++; last_ma = bus.mem_addr; end
                if (bus.mem_write) begin nwr++; last_ma = bus.mem_addr; last_wd = bus.mem_wdata; end
            end
            if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", {31'd0, bus.resp_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.v.er);
                    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.v.ee});
                    chk("latency", cyc - e.acc, e.v.lat);
                    chk("mem_read_cycles", nrd, e.v.nrd);
                    chk("mem_write_cycles", nwr, e.v.nwr);
                    if (e.v.nrd + e.v.nwr > 0) chk("mem_addr", {26'd0, last_ma}, {26'd0, e.v.ma});
                    if (e.v.nwr > 0) chk("mem_wdata", last_wd, e.v.ewd);
                end
                nrd = 0; nwr = 0;
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wd);
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
        bus.req_addr = addr;  bus.req_wdata = wd;
    endtask

    task automatic scramble();
        bus.req_valid  = 1'b0;
        bus.req_store  = $urandom_range(1, 0);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = 8'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic do_req(input vec_t v);
        int n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
        drive(v.st, v.f3, v.addr, v.wd);
        e.v = v; e.acc = cyc;
        q.push_back(e);
        @(negedge clk);
        chk("req_ready_after_accept", {31'd0, bus.req_ready}, 32'd0);
        scramble();
        n = 0;
        while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            chk("resp_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 8'd0;  bus.req_wdata = 32'd0;

        tbl[0]  = mk(1, 3'b010, 8'h04, 32'h12345678, 32'h0, 0, 2, 0, 1, 6'd1, 32'h12345678);
        tbl[1]  = mk(0, 3'b010, 8'h04, 32'h0, 32'h12345678, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[2]  = mk(1, 3'b000, 8'h05, 32'h000000AB, 32'h0, 0, 3, 1, 1, 6'd1, 32'h1234AB78);
        tbl[3]  = mk(0, 3'b010, 8'h04, 32'h0, 32'h1234AB78, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[4]  = mk(1, 3'b010, 8'h04, 32'h80345678, 32'h0, 0, 2, 0, 1, 6'd1, 32'h80345678);
        tbl[5]  = mk(0, 3'b000, 8'h07, 32'h0, 32'hFFFFFF80, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[6]  = mk(0, 3'b100, 8'h07, 32'h0, 32'h00000080, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[7]  = mk(0, 3'b101, 8'h06, 32'h0, 32'h00008034, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[8]  = mk(0, 3'b001, 8'h06, 32'h0, 32'hFFFF8034, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[9]  = mk(0, 3'b000, 8'h04, 32'h0, 32'h00000078, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[10] = mk(0, 3'b101, 8'h04, 32'h0, 32'h00005678, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[11] = mk(0, 3'b100, 8'h05, 32'h0, 32'h00000056, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[12] = mk(1, 3'b010, 8'h08, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 6'd2, 32'hDEADBEEF);
        tbl[13] = mk(0, 3'b010, 8'h08, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 6'd2, 32'h0);
        tbl[14] = mk(1, 3'b001, 8'h0A, 32'h1234CAFE, 32'h0, 0, 3, 1, 1, 6'd2, 32'hCAFEBEEF);
        tbl[15] = mk(0, 3'b010, 8'h08, 32'h0, 32'hCAFEBEEF, 0, 2, 1, 0, 6'd2, 32'h0);
        tbl[16] = mk(1, 3'b000, 8'h08, 32'h00000011, 32'h0, 0, 3, 1, 1, 6'd2, 32'hCAFEBE11);
        tbl[17] = mk(0, 3'b000, 8'h0B, 32'h0, 32'hFFFFFFCA, 0, 2, 1, 0, 6'd2, 32'h0);
        tbl[18] = TRAP ? mk(0, 3'b010, 8'h06, 32'h0, 32'h0, 1, 1, 0, 0, 6'd0, 32'h0)
                       : mk(0, 3'b010, 8'h06, 32'h0, 32'h80345678, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[19] = mk(0, 3'b011, 8'h04, 32'h0, 32'h0, TRAP, 1, 0, 0, 6'd0, 32'h0);
        tbl[20] = mk(0, 3'b110, 8'h04, 32'h0, 32'h0, TRAP, 1, 0, 0, 6'd0, 32'h0);
        tbl[21] = mk(1, 3'b100, 8'h08, 32'h55555555, 32'h0, TRAP, 1, 0, 0, 6'd0, 32'h0);
        tbl[22] = mk(1, 3'b011, 8'h08, 32'h55555555, 32'h0, TRAP, 1, 0, 0, 6'd0, 32'h0);
        tbl[23] = TRAP ? mk(0, 3'b001, 8'h05, 32'h0, 32'h0, 1, 1, 0, 0, 6'd0, 32'h0)
                       : mk(0, 3'b001, 8'h05, 32'h0, 32'h00005678, 0, 2, 1, 0, 6'd1, 32'h0);
        tbl[24] = TRAP ? mk(1, 3'b001, 8'h0B, 32'h00007777, 32'h0, 1, 1, 0, 0, 6'd0, 32'h0)
                       : mk(1, 3'b001, 8'h0B, 32'h00007777, 32'h0, 0, 3, 1, 1, 6'd2, 32'h7777BE11);
        tbl[25] = mk(0, 3'b010, 8'h08, 32'h0, TRAP ? 32'hCAFEBE11 : 32'h7777BE11, 0, 2, 1, 0, 6'd2, 32'h0);
        tbl[26] = TRAP ? mk(1, 3'b010, 8'h0E, 32'h01020304, 32'h0, 1, 1, 0, 0, 6'd0, 32'h0)
                       : mk(1, 3'b010, 8'h0E, 32'h01020304, 32'h0, 0, 2, 0, 1, 6'd3, 32'h01020304);
        tbl[27] = mk(0, 3'b110, 8'h0C, 32'h0, 32'h0, TRAP, 1, 0, 0, 6'd0, 32'h0);

        // Reset state, both during and after reset
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_resp_rdata", bus.resp_rdata, 32'd0);
        chk("idle_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("idle_mem_read", {31'd0, bus.mem_read}, 32'd0);
        chk("idle_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("idle_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        chk("idle_mem_wdata", bus.mem_wdata, 32'd0);

        for (int i = 0; i < 28; i++) do_req(tbl[i]);

        // sh aborted by rst while in READ: no write, no response, mem[1] untouched
        @(negedge clk);
        drive(1'b1, 3'b001, 8'h04, 32'h0000FFFF);
        @(negedge clk);
        scramble();
        chk("abort_read_mem_read", {31'd0, bus.mem_read}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_read_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_read_mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("abort_read_resp", {31'd0, bus.resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_read_mem1", mem[1], 32'h80345678);
        do_req(mk(0, 3'b010, 8'h04, 32'h0, 32'h80345678, 0, 2, 1, 0, 6'd1, 32'h0));

        // sw with rst during WRITE: the write still commits at that edge
        @(negedge clk);
        drive(1'b1, 3'b010, 8'h0C, 32'hA5A55A5A);
        @(negedge clk);
        scramble();
        chk("abort_write_mem_write", {31'd0, bus.mem_write}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_write_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_write_resp", {31'd0, bus.resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        do_req(mk(0, 3'b010, 8'h0C, 32'h0, 32'hA5A55A5A, 0, 2, 1, 0, 6'd3, 32'h0));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
